// File: rtl/cpu_prog_loader.sv
// Program-load and run controller: streams an instruction image into the core's
// instruction memory, holds the core in reset, then runs it for a bounded cycle budget.
module cpu_prog_loader #(
  parameter int unsigned INSTR_W    = 16,
  parameter int unsigned DEPTH      = 16,
  parameter int unsigned ADDR_W     = 4,
  parameter int unsigned RST_CYCLES = 2,
  parameter int unsigned RUN_CYCLES = 20,
  parameter int unsigned CNT_W      = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load_valid,
  output logic               load_ready,
  input  logic [INSTR_W-1:0] load_data,
  input  logic               load_last,
  input  logic               start,
  input  logic               halt,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_reset,
  output logic               busy,
  output logic               done,
  output logic               trunc,
  output logic [ADDR_W:0]    image_len,
  output logic [CNT_W-1:0]   cycle_count
);

  localparam int unsigned HoldW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
  localparam logic [HoldW-1:0]  HoldLast = HoldW'(RST_CYCLES - 1);
  localparam logic [ADDR_W-1:0] PtrLast  = ADDR_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0]  CntLast  = CNT_W'(RUN_CYCLES - 1);

  typedef enum logic [2:0] {StIdle, StLoad, StHold, StRun, StDone} state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [ADDR_W:0]     image_len_q, image_len_d;
  logic [CNT_W-1:0]    cycle_count_q, cycle_count_d;
  logic [HoldW-1:0]    hold_cnt_q, hold_cnt_d;
  logic                trunc_q, trunc_d;
  logic                imem_we_q, imem_we_d;
  logic [ADDR_W-1:0]   imem_addr_q, imem_addr_d;
  logic [INSTR_W-1:0]  imem_wdata_q, imem_wdata_d;
  logic                accepting;
  logic                xfer;

  assign accepting  = (state_q == StIdle) || (state_q == StLoad) || (state_q == StDone);
  assign load_ready = reset & accepting;
  assign xfer       = load_valid & load_ready;

  always_comb begin
    state_d       = state_q;
    wr_ptr_d      = wr_ptr_q;
    image_len_d   = image_len_q;
    cycle_count_d = cycle_count_q;
    hold_cnt_d    = hold_cnt_q;
    trunc_d       = trunc_q;
    imem_we_d     = 1'b0;
    imem_addr_d   = imem_addr_q;
    imem_wdata_d  = imem_wdata_q;

    if (xfer) begin
      imem_we_d    = 1'b1;
      imem_wdata_d = load_data;
    end

    unique case (state_q)
      StIdle, StDone: begin
        if (xfer) begin
          // A new image invalidates the old one until its last beat lands.
          imem_addr_d   = '0;
          wr_ptr_d      = ADDR_W'(1);
          trunc_d       = 1'b0;
          cycle_count_d = '0;
          hold_cnt_d    = '0;
          image_len_d   = '0;
          if (load_last) begin
            image_len_d = (ADDR_W+1)'(1);
            state_d     = StHold;
          end else begin
            state_d = StLoad;
          end
        end else if (start && (image_len_q != '0)) begin
          cycle_count_d = '0;
          hold_cnt_d    = '0;
          state_d       = StHold;
        end
      end
      StLoad: begin
        if (xfer) begin
          imem_addr_d = wr_ptr_q;
          wr_ptr_d    = wr_ptr_q + ADDR_W'(1);
          if (load_last) begin
            image_len_d   = {1'b0, wr_ptr_q} + (ADDR_W+1)'(1);
            cycle_count_d = '0;
            hold_cnt_d    = '0;
            state_d       = StHold;
          end else if (wr_ptr_q == PtrLast) begin
            image_len_d   = (ADDR_W+1)'(DEPTH);
            trunc_d       = 1'b1;
            cycle_count_d = '0;
            hold_cnt_d    = '0;
            state_d       = StHold;
          end
        end
      end
      StHold: begin
        // The final write cycle is not part of the reset hold window.
        if (!imem_we_q) begin
          if (hold_cnt_q == HoldLast) begin
            hold_cnt_d = '0;
            state_d    = StRun;
          end else begin
            hold_cnt_d = hold_cnt_q + HoldW'(1);
          end
        end
      end
      StRun: begin
        cycle_count_d = cycle_count_q + CNT_W'(1);
        if (halt || (cycle_count_q == CntLast)) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q       <= StIdle;
      wr_ptr_q      <= '0;
      image_len_q   <= '0;
      cycle_count_q <= '0;
      hold_cnt_q    <= '0;
      trunc_q       <= 1'b0;
      imem_we_q     <= 1'b0;
      imem_addr_q   <= '0;
      imem_wdata_q  <= '0;
    end else begin
      state_q       <= state_d;
      wr_ptr_q      <= wr_ptr_d;
      image_len_q   <= image_len_d;
      cycle_count_q <= cycle_count_d;
      hold_cnt_q    <= hold_cnt_d;
      trunc_q       <= trunc_d;
      imem_we_q     <= imem_we_d;
      imem_addr_q   <= imem_addr_d;
      imem_wdata_q  <= imem_wdata_d;
    end
  end

  assign imem_we     = imem_we_q;
  assign imem_addr   = imem_addr_q;
  assign imem_wdata  = imem_wdata_q;
  assign cpu_reset   = ~reset | (state_q != StRun);
  assign busy        = (state_q == StLoad) || (state_q == StHold) || (state_q == StRun);
  assign done        = (state_q == StDone);
  assign trunc       = trunc_q;
  assign image_len   = image_len_q;
  assign cycle_count = cycle_count_q;

endmodule

// File: tb/tb_cpu_prog_loader.sv
// Scoreboard bench for cpu_prog_loader: stimulus queues expected writes and run results,
// a monitor pops and compares them as the DUT presents writes and completions.
module tb_cpu_prog_loader;

  localparam int unsigned RstCycles = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        load_valid = 1'b0;
  logic        load_ready;
  logic [15:0] load_data = '0;
  logic        load_last = 1'b0;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        imem_we;
  logic [3:0]  imem_addr;
  logic [15:0] imem_wdata;
  logic        cpu_reset;
  logic        busy;
  logic        done;
  logic        trunc;
  logic [4:0]  image_len;
  logic [15:0] cycle_count;

  cpu_prog_loader dut (
    .clk         (clk),
    .reset       (reset),
    .load_valid  (load_valid),
    .load_ready  (load_ready),
    .load_data   (load_data),
    .load_last   (load_last),
    .start       (start),
    .halt        (halt),
    .imem_we     (imem_we),
    .imem_addr   (imem_addr),
    .imem_wdata  (imem_wdata),
    .cpu_reset   (cpu_reset),
    .busy        (busy),
    .done        (done),
    .trunc       (trunc),
    .image_len   (image_len),
    .cycle_count (cycle_count)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0]  addr;
    logic [15:0] data;
  } wr_t;

  typedef struct {
    int cc;
    int len;
    int tr;
  } run_t;

  wr_t  wr_q[$];
  run_t run_q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   hold_n = 0;
  int   run_n = 0;
  logic prev_cr = 1'b1;
  logic prev_done = 1'b0;
  logic [15:0] img [4] = '{16'h1123, 16'h2345, 16'h4567, 16'h6789};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic push_wr(input int a, input int d);
    wr_t w;
    w.addr = a[3:0];
    w.data = d[15:0];
    wr_q.push_back(w);
  endtask

  task automatic push_run(input int cc, input int len, input int tr);
    run_t r;
    r.cc  = cc;
    r.len = len;
    r.tr  = tr;
    run_q.push_back(r);
  endtask

  task automatic send(input logic [15:0] d, input logic last);
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = d;
    load_last  = last;
    @(posedge clk);
  endtask

  task automatic idle_bus();
    @(negedge clk);
    load_valid = 1'b0;
    load_last  = 1'b0;
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    int n = 0;
    while (!done && n < budget) begin
      @(negedge clk);
      n++;
    end
    check("done_reached", done, 1);
  endtask

  // Monitor: compares writes and run completions against the queued expectations.
  initial begin
    wr_t  w;
    run_t r;
    forever begin
      @(negedge clk);
      if (!reset) begin
        hold_n    = 0;
        run_n     = 0;
        prev_cr   = 1'b1;
        prev_done = 1'b0;
      end else begin
        if (imem_we) begin
          if (wr_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected",
                     imem_addr, imem_wdata);
          end else begin
            w = wr_q.pop_front();
            check("imem_addr", imem_addr, w.addr);
            check("imem_wdata", imem_wdata, w.data);
          end
          hold_n = 0;
        end else if (busy && cpu_reset) begin
          hold_n++;
        end
        if (!busy) hold_n = 0;
        if (prev_cr && !cpu_reset) check("hold_cycles", hold_n, RstCycles);
        if (!cpu_reset) run_n++;
        if (done && !prev_done) begin
          if (run_q.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_done: cycle_count %0d, no completion expected",
                     cycle_count);
          end else begin
            r = run_q.pop_front();
            check("cycle_count", cycle_count, r.cc);
            check("image_len", image_len, r.len);
            check("trunc", trunc, r.tr);
            check("run_cycles_seen", run_n, r.cc);
          end
          run_n = 0;
        end
        prev_cr   = cpu_reset;
        prev_done = done;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("rst_cpu_reset", cpu_reset, 1);
    check("rst_load_ready", load_ready, 1);
    check("rst_done", done, 0);
    check("rst_image_len", image_len, 0);
    check("rst_imem_we", imem_we, 0);

    // start with an empty image is ignored
    pulse_start();
    check("empty_start_busy", busy, 0);
    check("empty_start_done", done, 0);

    // Four-word image, full run budget
    for (int i = 0; i < 4; i++) push_wr(i, img[i]);
    push_run(20, 4, 0);
    for (int i = 0; i < 4; i++) send(img[i], i == 3);
    idle_bus();
    wait_done(100);
    check("done_cpu_reset", cpu_reset, 1);

    // halt in DONE is ignored
    @(negedge clk);
    halt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    halt = 1'b0;
    check("halt_in_done", done, 1);

    // Re-run, halted on the run cycle where cycle_count is 6
    push_run(7, 4, 0);
    pulse_start();
    n = 0;
    while (!(cycle_count == 16'd6 && !cpu_reset) && n < 100) begin
      @(negedge clk);
      n++;
    end
    check("halt_point_reached", n < 100, 1);
    halt = 1'b1;
    @(posedge clk);
    @(negedge clk);
    halt = 1'b0;
    check("halt_done", done, 1);
    check("halt_cpu_reset", cpu_reset, 1);

    // 17 beats without last: truncated at 16
    for (int i = 0; i < 16; i++) push_wr(i, 16'hA000 + i);
    push_run(20, 16, 1);
    for (int i = 0; i < 16; i++) send(16'hA000 + i[15:0], 1'b0);
    @(negedge clk);
    load_data = 16'hA010;
    check("trunc_ready_low", load_ready, 0);
    @(posedge clk);
    idle_bus();
    wait_done(100);

    // start from DONE re-runs without writes
    push_run(20, 16, 1);
    pulse_start();
    wait_done(100);

    // Reset in the middle of a load
    push_wr(0, 16'h0BAD);
    push_wr(1, 16'h0C0D);
    send(16'h0BAD, 1'b0);
    send(16'h0C0D, 1'b0);
    idle_bus();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    #1;
    check("midload_image_len", image_len, 0);
    check("midload_cpu_reset", cpu_reset, 1);
    check("midload_busy", busy, 0);
    check("midload_trunc", trunc, 0);
    pulse_start();
    check("midload_start_busy", busy, 0);

    repeat (3) @(negedge clk);
    check("wr_queue_drained", wr_q.size(), 0);
    check("run_queue_drained", run_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
